tnoc_vc_arbiter: RTL and testbench

//  Packet-level arbiter that shares one output port among CONFIG.virtual_channels VCs.

---
 rtl/tnoc_config_pkg.sv | 29 ++
 rtl/tnoc_vc_rr_select.sv | 37 +++
 rtl/tnoc_vc_arbiter.sv | 126 ++++++++++++
 tb/tb_tnoc_vc_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tnoc_config_pkg.sv
// Shared NoC configuration record, defaults and arbiter state type.
// Sizing helpers used by the VC arbiter and its round-robin picker.
package tnoc_config_pkg;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned address_x_width;
        int unsigned address_y_width;
        int unsigned data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        address_x_width:  3,
        address_y_width:  3,
        data_width:       32
    };

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tnoc_vc_arbiter_state_e;

    // A single VC still needs a 1-bit index so ports never collapse to zero width.
    function automatic int index_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/tnoc_vc_rr_select.sv
// Combinational round-robin picker: first eligible VC at or after pointer, wrapping.
// Latency: 0 cycles (pure logic). Backpressure: none; the caller decides when to load the result.
module tnoc_vc_rr_select #(
    parameter int CHANNELS = 2,
    parameter int INDEX_W  = 1
)(
    input  logic [CHANNELS-1:0] eligible,
    input  logic [INDEX_W-1:0]  pointer,
    output logic                found,
    output logic [CHANNELS-1:0] winner,
    output logic [INDEX_W-1:0]  winner_index
);

    logic [CHANNELS-1:0]   upper_mask;
    logic [2*CHANNELS-1:0] doubled;
    logic [2*CHANNELS-1:0] doubled_pick;

    // Low half holds only VCs at/after the pointer; high half is the wrapped copy,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    always_comb begin
        upper_mask   = ~((CHANNELS'(1) << pointer) - CHANNELS'(1));
        doubled      = {eligible, eligible & upper_mask};
        doubled_pick = doubled & (~doubled + {{(2*CHANNELS-1){1'b0}}, 1'b1});
        winner       = doubled_pick[CHANNELS-1:0] | doubled_pick[2*CHANNELS-1:CHANNELS];
        found        = |eligible;
    end

    always_comb begin
        winner_index = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner[i]) begin
                winner_index = INDEX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tnoc_vc_arbiter.sv
// Packet-level round-robin VC arbiter; grant locked until the tail flit handshakes (i_free).
// Latency: request -> registered grant 1 cycle; TNOC_VC_ARBITER_BACK_TO_BACK_EN re-grants on i_free.
// Backpressure: none here; flit stalls are absorbed by ready while the grant stays locked.
module tnoc_vc_arbiter
    import tnoc_config_pkg::*;
#(
    parameter  tnoc_config CONFIG   = TNOC_DEFAULT_CONFIG,
    localparam int         CHANNELS = int'(CONFIG.virtual_channels),
    localparam int         INDEX_W  = index_width(CHANNELS)
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_request,
    input  logic [CHANNELS-1:0] i_vc_available,
    input  logic                i_free,
    output logic [CHANNELS-1:0] o_grant,
    output logic                o_grant_valid,
    output logic [INDEX_W-1:0]  o_grant_index
);

    tnoc_vc_arbiter_state_e state_q;
    tnoc_vc_arbiter_state_e state_d;

    logic [CHANNELS-1:0] eligible;
    logic                found;
    logic [CHANNELS-1:0] winner;
    logic [INDEX_W-1:0]  winner_index;
    logic [INDEX_W-1:0]  pointer_q;
    logic [INDEX_W-1:0]  pointer_next;
    logic [CHANNELS-1:0] grant_q;
    logic [INDEX_W-1:0]  index_q;
    logic                load_grant;
    logic                clear_grant;

    // A VC only competes when downstream can take a whole new packet.
    assign eligible = i_request & i_vc_available;

    tnoc_vc_rr_select #(
        .CHANNELS (CHANNELS),
        .INDEX_W  (INDEX_W)
    ) u_rr_select (
        .eligible     (eligible),
        .pointer      (pointer_q),
        .found        (found),
        .winner       (winner),
        .winner_index (winner_index)
    );

    assign pointer_next = (winner_index == INDEX_W'(CHANNELS - 1)) ? '0 : winner_index + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (found) state_d = BUSY;
            BUSY: begin
                if (i_free) begin
`ifdef TNOC_VC_ARBITER_BACK_TO_BACK_EN
                    state_d = found ? BUSY : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_grant  = 1'b0;
        clear_grant = 1'b0;
        case (state_q)
            IDLE: load_grant = found;
            BUSY: begin
                if (i_free) begin
`ifdef TNOC_VC_ARBITER_BACK_TO_BACK_EN
                    load_grant  = found;
                    clear_grant = !found;
`else
                    clear_grant = 1'b1;
`endif
                end
            end
            default: clear_grant = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_q   <= '0;
            index_q   <= '0;
            pointer_q <= '0;
        end else if (load_grant) begin
            grant_q   <= winner;
            index_q   <= winner_index;
            pointer_q <= pointer_next;
        end else if (clear_grant) begin
            grant_q <= '0;
            index_q <= '0;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_valid = |grant_q;
    assign o_grant_index = index_q;

    // Protocol checks on the requesters; the hardware tolerates both violations.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(state_q == IDLE && i_free))
                else $error("tnoc_vc_arbiter: i_free asserted while idle");
            assert (!(state_q == BUSY && !i_free && !i_request[index_q]))
                else $error("tnoc_vc_arbiter: granted VC %0d dropped request before tail", index_q);
            assert ($onehot0(grant_q))
                else $error("tnoc_vc_arbiter: grant not one-hot: %b", grant_q);
        end
    end

endmodule

// File: tb/tb_tnoc_vc_arbiter.sv
// Directed plus random checks of tnoc_vc_arbiter (4 VCs) against a packet-level reference model.
module tb_tnoc_vc_arbiter;
    import tnoc_config_pkg::*;

    localparam tnoc_config CFG = '{
        virtual_channels: 4,
        address_x_width:  3,
        address_y_width:  3,
        data_width:       32
    };
    localparam int N = 4;
`ifdef TNOC_VC_ARBITER_BACK_TO_BACK_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] avail;
    logic         free;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_index;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: granted VC (-1 when idle) and round-robin start point.
    int m_gnt = -1;
    int m_ptr = 0;
    int age   = 0;

    int           order_q[$];
    int           exp_order[5];
    logic [N-1:0] prev_grant;
    logic [N-1:0] r;
    logic         f;

    always #5 clk = ~clk;

    tnoc_vc_arbiter #(.CONFIG(CFG)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_request      (req),
        .i_vc_available (avail),
        .i_free         (free),
        .o_grant        (grant),
        .o_grant_valid  (grant_valid),
        .o_grant_index  (grant_index)
    );

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (elig[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int w;
        w = pick(req & avail, m_ptr);
        if (rst) begin
            m_gnt = -1;
            m_ptr = 0;
        end else if (m_gnt >= 0 && !free) begin
            m_gnt = m_gnt;
        end else if (m_gnt >= 0 && !BTB) begin
            m_gnt = -1;
        end else if (w >= 0) begin
            m_gnt = w;
            m_ptr = (w + 1) % N;
        end else begin
            m_gnt = -1;
        end
    endtask

    task automatic step(input logic s_rst, input logic [N-1:0] s_req, input logic [N-1:0] s_avail,
                        input logic s_free, input string tag);
        int           prev;
        logic [N-1:0] one;
        logic [N-1:0] exp_g;
        rst   = s_rst;
        req   = s_req;
        avail = s_avail;
        free  = s_free;
        prev  = m_gnt;
        model_update();
        age   = (m_gnt != prev) ? 0 : age + 1;
        @(posedge clk);
        #1;
        one   = 1;
        exp_g = (m_gnt < 0) ? '0 : (one << m_gnt);
        chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_gnt >= 0));
        chk({tag, ".index"}, 32'(grant_index), (m_gnt < 0) ? 32'd0 : 32'(m_gnt));
    endtask

    initial begin
        rst = 1'b1; req = '0; avail = '0; free = 1'b0;
        step(1, 4'b0000, 4'b0000, 0, "reset0");
        step(1, 4'b0011, 4'b1111, 0, "reset1");

        // Two requesters: VC0 first from reset, then VC1 after its release.
        step(0, 4'b0011, 4'b1111, 0, "t1_first");
        step(0, 4'b0011, 4'b1111, 1, "t1_free");
        step(0, 4'b0010, 4'b1111, 0, "t1_second");
        step(0, 4'b0010, 4'b1111, 1, "t1_free2");
        step(0, 4'b0000, 4'b1111, 0, "t1_idle");

        // All four requesting, tail on the third grant cycle: order 0,1,2,3,0.
        step(1, 4'b0000, 4'b1111, 0, "t2_rst");
        prev_grant = '0;
        for (int c = 0; c < 24; c++) begin
            step(0, 4'b1111, 4'b1111, (m_gnt >= 0 && age == 2), "t2");
            if (grant_valid && grant != prev_grant) order_q.push_back(int'(grant_index));
            prev_grant = grant;
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_count_ok", 32'(order_q.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < order_q.size()) chk($sformatf("t2_order%0d", k), 32'(order_q[k]), 32'(exp_order[k]));
        end
        step(0, 4'b0000, 4'b1111, (m_gnt >= 0), "t2_drain");
        step(0, 4'b0000, 4'b1111, 0, "t2_idle");

        // Request without downstream space never wins.
        step(1, 4'b0000, 4'b0000, 0, "t3_rst");
        step(0, 4'b0001, 4'b0010, 0, "t3_blocked0");
        step(0, 4'b0001, 4'b0010, 0, "t3_blocked1");
        step(0, 4'b0001, 4'b0011, 0, "t3_avail");
        step(0, 4'b0000, 4'b0011, 1, "t3_free");

        // Single-flit packet on VC0 with VC1 waiting.
        step(1, 4'b0000, 4'b1111, 0, "t4_rst");
        step(0, 4'b0011, 4'b1111, 0, "t4_grant0");
        step(0, 4'b0010, 4'b1111, 1, "t4_single");
        step(0, 4'b0010, 4'b1111, 0, "t4_next");
        step(0, 4'b0010, 4'b1111, 0, "t4_next2");

        // Reset while busy on VC1 drops the grant and restarts priority at VC0.
        step(1, 4'b0000, 4'b1111, 0, "t5_rst");
        step(0, 4'b0010, 4'b1111, 0, "t5_busy1");
        step(1, 4'b0010, 4'b1111, 0, "t5_midrst");
        step(0, 4'b0011, 4'b1111, 0, "t5_vc0");

        // Downstream availability drops mid-packet: grant stays locked.
        step(0, 4'b0011, 4'b1110, 0, "t6_drop0");
        step(0, 4'b0011, 4'b0000, 0, "t6_drop1");
        step(0, 4'b0011, 4'b0000, 1, "t6_free");

        // Random traffic obeying the request protocol.
        for (int c = 0; c < 600; c++) begin
            r = req;
            f = (m_gnt >= 0) && ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                if (f && i == m_gnt)  r[i] = ($urandom_range(0, 1) == 0);
                else if (i == m_gnt)  r[i] = 1'b1;
                else if (!r[i])       r[i] = ($urandom_range(0, 2) == 0);
            end
            step(($urandom_range(0, 99) == 0), r, 4'($urandom_range(0, 15) | $urandom_range(0, 15)),
                 f, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
